// File: rtl/rf_wb_arb.sv
// Write-back arbiter and RAW scoreboard for the register file's single write port.
// Optional macro RF_WB_FWD_EN adds forwarding outputs and clears busy at the transfer edge.
module rf_wb_arb #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*5-1:0] req_reg,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]   req_rdy,
  input  logic              clm_vld,
  input  logic [4:0]        clm_reg,
  input  logic [4:0]        chk_reg1,
  input  logic [4:0]        chk_reg2,
  output logic              hazard,
  output logic              claim_err,
  output logic              rf_wr,
  output logic [4:0]        wr_reg,
  output logic [31:0]       wr_data
`ifdef RF_WB_FWD_EN
  ,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [31:0]       fwd_data1,
  output logic [31:0]       fwd_data2
`endif
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;
  logic          xfer;
  logic [4:0]    sel_reg;
  logic [31:0]   sel_data;
  logic [31:0]   busy;
  logic [31:0]   set_vec;
  logic [31:0]   clr_vec;

  logic [4:0]  reg_a  [NREQ];
  logic [31:0] data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign reg_a[g]  = req_reg[g*5 +: 5];
    assign data_a[g] = req_data[g*32 +: 32];
  end

  // Round-robin scan starting at ptr; only req_vld and ptr feed the grant.
  always_comb begin
    logic [PW-1:0] idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign xfer     = found & rst;
  assign req_rdy  = xfer ? (NREQ'(1) << win) : '0;
  assign sel_reg  = reg_a[win];
  assign sel_data = data_a[win];

  // NOTE: sequential state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      rf_wr   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else if (xfer) begin
      ptr     <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      rf_wr   <= (sel_reg != 5'd0);
      wr_reg  <= sel_reg;
      wr_data <= sel_data;
    end else begin
      rf_wr   <= 1'b0;
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (clm_vld && clm_reg != 5'd0) set_vec[clm_reg] = 1'b1;
`ifdef RF_WB_FWD_EN
    if (xfer && sel_reg != 5'd0) clr_vec[sel_reg] = 1'b1;
`else
    if (rf_wr && wr_reg != 5'd0) clr_vec[wr_reg] = 1'b1;
`endif
  end

  // NOTE: busy is architectural state that decode trusts immediately, so the whole vector is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      claim_err <= 1'b0;
    end else begin
      // Set after clear: a new claim outranks the retiring producer.
      busy <= (busy & ~clr_vec) | set_vec;
      if (clm_vld && clm_reg != 5'd0 && busy[clm_reg] && !clr_vec[clm_reg])
        claim_err <= 1'b1;
    end
  end

  assign hazard = (chk_reg1 != 5'd0 && busy[chk_reg1]) ||
                  (chk_reg2 != 5'd0 && busy[chk_reg2]);

`ifdef RF_WB_FWD_EN
  assign fwd_hit1  = rf_wr && (wr_reg == chk_reg1) && (chk_reg1 != 5'd0);
  assign fwd_hit2  = rf_wr && (wr_reg == chk_reg2) && (chk_reg2 != 5'd0);
  assign fwd_data1 = wr_data;
  assign fwd_data2 = wr_data;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: directed scenarios plus randomized traffic
// compared against a behavioural model of arbitration, write stage and scoreboard.
module tb_rf_wb_arb;
  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_vld;
  logic [NREQ*5-1:0] req_reg;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]   req_rdy;
  logic              clm_vld;
  logic [4:0]        clm_reg, chk_reg1, chk_reg2;
  logic              hazard, claim_err, rf_wr;
  logic [4:0]        wr_reg;
  logic [31:0]       wr_data;
`ifdef RF_WB_FWD_EN
  logic              fwd_hit1, fwd_hit2;
  logic [31:0]       fwd_data1, fwd_data2;
`endif

  rf_wb_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_reg(req_reg), .req_data(req_data), .req_rdy(req_rdy),
    .clm_vld(clm_vld), .clm_reg(clm_reg), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .hazard(hazard), .claim_err(claim_err),
    .rf_wr(rf_wr), .wr_reg(wr_reg), .wr_data(wr_data)
`ifdef RF_WB_FWD_EN
    , .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side stimulus (held stable until granted)
  bit        s_vld  [NREQ];
  bit [4:0]  s_reg  [NREQ];
  bit [31:0] s_data [NREQ];

  // Reference model state
  int        m_ptr;
  bit [31:0] m_busy;
  bit        m_err;
  bit        m_rf_wr;
  bit [4:0]  m_wr_reg;
  bit [31:0] m_wr_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (s_vld[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_busy_of(input bit [4:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_err = 0; m_rf_wr = 0; m_wr_reg = '0; m_wr_data = '0;
  endtask

  task automatic model_update();
    int w   = m_winner();
    int clr = -1;
`ifdef RF_WB_FWD_EN
    if (w >= 0 && s_reg[w] != 0) clr = int'(s_reg[w]);
`else
    if (m_rf_wr && m_wr_reg != 0) clr = int'(m_wr_reg);
`endif
    if (clm_vld && clm_reg != 0 && m_busy[clm_reg] && int'(clm_reg) != clr) m_err = 1;
    if (clr > 0) m_busy[clr] = 1'b0;
    if (clm_vld && clm_reg != 0) m_busy[clm_reg] = 1'b1;
    if (w >= 0) begin
      m_rf_wr   = (s_reg[w] != 0);
      m_wr_reg  = s_reg[w];
      m_wr_data = s_data[w];
      m_ptr     = (w + 1) % NREQ;
      s_vld[w]  = 1'b0;
    end else begin
      m_rf_wr = 1'b0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_vld[i]          = s_vld[i];
      req_reg[i*5 +: 5]   = s_reg[i];
      req_data[i*32 +: 32] = s_data[i];
    end
    #1;
  endtask

  task automatic check_outputs();
    int w = m_winner();
    logic [NREQ-1:0] exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    check("hazard", 32'(hazard), 32'(m_busy_of(chk_reg1) | m_busy_of(chk_reg2)));
    check("rf_wr", 32'(rf_wr), 32'(m_rf_wr));
    check("wr_reg", 32'(wr_reg), 32'(m_wr_reg));
    check("wr_data", wr_data, m_wr_data);
    check("claim_err", 32'(claim_err), 32'(m_err));
`ifdef RF_WB_FWD_EN
    check("fwd_hit1", 32'(fwd_hit1), 32'(m_rf_wr && m_wr_reg == chk_reg1 && chk_reg1 != 0));
    check("fwd_hit2", 32'(fwd_hit2), 32'(m_rf_wr && m_wr_reg == chk_reg2 && chk_reg2 != 0));
    check("fwd_data1", fwd_data1, m_wr_data);
`endif
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NREQ; i++) begin
      s_vld[i] = 0; s_reg[i] = '0; s_data[i] = '0;
    end
    clm_vld = 0; clm_reg = '0; chk_reg1 = '0; chk_reg2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      s_vld[i] = 1; s_reg[i] = 5'(i + 1); s_data[i] = $urandom;
    end
    chk_reg1 = 5'd5; chk_reg2 = 5'd9; clm_vld = 0;
    drive();
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_rf_wr", 32'(rf_wr), 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    check("rst_claim_err", 32'(claim_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    drive();
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    drive();
    model_reset();

    // Reset with all requesters valid
    do_reset();

    // Round-robin with all three requesters continuously valid
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        s_vld[i] = 1; s_reg[i] = 5'(i + 1); s_data[i] = $urandom;
      end
      drive();
      check("rr_grant", 32'(req_rdy), 32'(1 << (k % 3)));
      if (k > 0) begin
        check("rr_rf_wr", 32'(rf_wr), 32'd1);
        check("rr_wr_reg", 32'(wr_reg), 32'((k - 1) % 3 + 1));
      end
      tick();
    end
    idle_inputs();
    drive();
    check("rr_last_wr_reg", 32'(wr_reg), 32'd3);
    tick();

    // Write to $0: handshake completes, no RF write
    do_reset();
    s_vld[0] = 1; s_reg[0] = 5'd0; s_data[0] = 32'hDEAD_BEEF;
    drive();
    check("r0_grant", 32'(req_rdy), 32'd1);
    tick();
    drive();
    check("r0_no_wr", 32'(rf_wr), 32'd0);
    tick();

    // Scoreboard: claim r5, write it back through requester 1
    do_reset();
    clm_vld = 1; clm_reg = 5'd5;
    drive();
    tick();
    clm_vld = 0; chk_reg1 = 5'd5;
    drive();
    check("sb_claimed", 32'(hazard), 32'd1);
    tick();
    s_vld[1] = 1; s_reg[1] = 5'd5; s_data[1] = 32'h1234_5678;
    drive();
    check("sb_xfer_hazard", 32'(hazard), 32'd1);
    tick();
    drive();
    check("sb_wr_cycle_rf_wr", 32'(rf_wr), 32'd1);
`ifdef RF_WB_FWD_EN
    check("sb_wr_cycle_hazard", 32'(hazard), 32'd0);
    check("sb_fwd_hit1", 32'(fwd_hit1), 32'd1);
`else
    check("sb_wr_cycle_hazard", 32'(hazard), 32'd1);
`endif
    tick();
    drive();
    check("sb_after_hazard", 32'(hazard), 32'd0);
    tick();

    // Collision: reclaim r7 in the cycle its write retires, then claim it again
    do_reset();
    clm_vld = 1; clm_reg = 5'd7;
    drive();
    tick();
    clm_vld = 0; chk_reg1 = 5'd7;
    s_vld[2] = 1; s_reg[2] = 5'd7; s_data[2] = 32'hCAFE_0007;
    drive();
    tick();
    clm_vld = 1; clm_reg = 5'd7;
    drive();
    check("col_rf_wr", 32'(rf_wr), 32'd1);
    tick();
    clm_vld = 0;
    drive();
    check("col_busy_kept", 32'(hazard), 32'd1);
    check("col_no_err", 32'(claim_err), 32'd0);
    tick();
    clm_vld = 1; clm_reg = 5'd7;
    drive();
    tick();
    clm_vld = 0;
    for (int k = 0; k < 3; k++) begin
      drive();
      check("col_err_sticky", 32'(claim_err), 32'd1);
      tick();
    end

    // Reset mid-write: r9 granted, then reset before the edge
    do_reset();
    clm_vld = 1; clm_reg = 5'd9;
    drive();
    tick();
    clm_vld = 0; chk_reg2 = 5'd9;
    s_vld[0] = 1; s_reg[0] = 5'd9; s_data[0] = 32'h0000_0009;
    drive();
    tick();
    s_vld[1] = 1; s_reg[1] = 5'd9; s_data[1] = 32'h9999_9999;
    drive();
    check("mid_grant", 32'(req_rdy), 32'd2);
    rst = 1'b0;
    #1;
    check("mid_rdy_in_rst", 32'(req_rdy), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rf_wr_in_rst", 32'(rf_wr), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    model_reset();
    chk_reg2 = 5'd9;
    for (int i = 0; i < NREQ; i++) begin
      s_vld[i] = 1; s_reg[i] = 5'(i + 10); s_data[i] = $urandom;
    end
    drive();
    check("mid_ptr0", 32'(req_rdy), 32'd1);
    check("mid_busy_clr", 32'(hazard), 32'd0);
    check("mid_no_wr", 32'(rf_wr), 32'd0);
    tick();

    // Randomized traffic in short segments separated by reset
    for (int seg = 0; seg < 10; seg++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!s_vld[i] && $urandom_range(0, 2) != 0) begin
            s_vld[i]  = 1;
            s_reg[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            s_data[i] = $urandom;
          end
        end
        clm_vld  = ($urandom_range(0, 4) == 0);
        clm_reg  = 5'($urandom_range(0, 7));
        chk_reg1 = 5'($urandom_range(0, 7));
        chk_reg2 = 5'($urandom_range(0, 31));
        drive();
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
